mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 144 ++++++++++++++
 tb/tb_mem_responder.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-port word memory responder with fixed wait states.
// Two top addresses map to an output register and a sampled input port.
module mem_responder #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        input_req_valid,
    output logic        output_req_ready,
    input  logic        input_req_we,
    input  logic [15:0] input_req_addr,
    input  logic [15:0] input_req_wdata,
    output logic        output_rsp_valid,
    output logic [15:0] output_rsp_rdata,
    input  logic [15:0] input_io_in,
    output logic [15:0] output_io_out
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [2:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;
    localparam logic [15:0] IO_OUT_ADDR = 16'hFFFF;
    localparam logic [15:0] IO_IN_ADDR  = 16'hFFFE;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [15:0] addr_q, wdata_q;
    logic [15:0] rdata_q, rdata_d;
    logic [15:0] io_out_q, io_out_d;
    logic [15:0] io_in_q;
    logic [15:0] ram_q [DEPTH];

    logic        accept;
    logic        commit;
    logic        ram_we;
    logic        acc_we;
    logic [15:0] acc_addr, acc_wdata;
    logic [DEPTH_LOG2-1:0] idx;

    assign accept = (state_q == IDLE) && input_req_valid;

    // With zero wait states the commit edge is the accept edge itself,
    // so the access must see the live request rather than the capture.
    assign acc_we    = (state_q == IDLE) ? input_req_we    : we_q;
    assign acc_addr  = (state_q == IDLE) ? input_req_addr  : addr_q;
    assign acc_wdata = (state_q == IDLE) ? input_req_wdata : wdata_q;
    assign idx       = acc_addr[DEPTH_LOG2-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (input_req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdata_d  = rdata_q;
        io_out_d = io_out_q;
        ram_we   = 1'b0;
        if (commit) begin
            if (acc_we) begin
                rdata_d = acc_wdata;
                if (acc_addr == IO_OUT_ADDR) begin
                    io_out_d = acc_wdata;
                end else if (acc_addr != IO_IN_ADDR) begin
                    ram_we = 1'b1;
                end
            end else if (acc_addr == IO_OUT_ADDR) begin
                rdata_d = io_out_q;
            end else if (acc_addr == IO_IN_ADDR) begin
                rdata_d = io_in_q;
            end else begin
                rdata_d = ram_q[idx];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            we_q     <= 1'b0;
            addr_q   <= 16'h0000;
            wdata_q  <= 16'h0000;
            rdata_q  <= 16'h0000;
            io_out_q <= 16'h0000;
            io_in_q  <= 16'h0000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            io_out_q <= io_out_d;
            io_in_q  <= input_io_in;
            if (accept) begin
                we_q    <= input_req_we;
                addr_q  <= input_req_addr;
                wdata_q <= input_req_wdata;
            end
        end
    end

    // RAM keeps its contents across reset; no write while reset is held.
    always_ff @(posedge CLK) begin
        if (ram_we && RST_N) begin
            ram_q[idx] <= acc_wdata;
        end
    end

    assign output_req_ready = (state_q == IDLE);
    assign output_rsp_valid = (state_q == RESP);
    assign output_rsp_rdata = rdata_q;
    assign output_io_out    = io_out_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one instance with one wait state,
// a second with none for back-to-back throughput.
module tb_mem_responder;

    localparam int W = 1;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = 16'h0;
    logic [15:0] req_wdata = 16'h0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic [15:0] io_in = 16'h0;
    logic [15:0] io_out;

    logic        rst0_n = 1'b0;
    logic        valid0 = 1'b0;
    logic        ready0;
    logic [15:0] wdata0 = 16'h0;
    logic        rsp0;
    logic [15:0] rdata0;
    logic [15:0] io_out0;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          cyc;
    } txn_t;

    txn_t        q[$];
    txn_t        q0[$];
    logic [15:0] mem_m [1024];
    logic [15:0] io_m = 16'h0;
    int          cyc = 0;
    int          cyc0 = 0;
    logic        prev_rsp = 1'b0;
    logic        prev_rsp0 = 1'b0;
    logic        stream = 1'b0;
    logic        have_last = 1'b0;
    logic        have_last0 = 1'b0;
    int          last_acc = 0;
    int          last_acc0 = 0;

    always #5 CLK = ~CLK;

    mem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(W)) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .input_req_valid(req_valid),
        .output_req_ready(req_ready),
        .input_req_we(req_we),
        .input_req_addr(req_addr),
        .input_req_wdata(req_wdata),
        .output_rsp_valid(rsp_valid),
        .output_rsp_rdata(rsp_rdata),
        .input_io_in(io_in),
        .output_io_out(io_out)
    );

    mem_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut0 (
        .CLK(CLK),
        .RST_N(rst0_n),
        .input_req_valid(valid0),
        .output_req_ready(ready0),
        .input_req_we(1'b1),
        .input_req_addr(16'h0007),
        .input_req_wdata(wdata0),
        .output_rsp_valid(rsp0),
        .output_rsp_rdata(rdata0),
        .input_io_in(16'h0000),
        .output_io_out(io_out0)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected data is formed when the response appears, so a request
    // dropped by reset never touches the model.
    always @(negedge CLK) begin
        txn_t        t;
        logic [15:0] e;
        cyc++;
        if (!RST_N) begin
            q.delete();
            io_m      = 16'h0;
            have_last = 1'b0;
        end else begin
            if (rsp_valid) begin
                chk("rsp_gap", {31'd0, prev_rsp}, 32'd0);
                if (q.size() == 0) begin
                    chk("rsp_spurious", 32'd1, 32'd0);
                end else begin
                    t = q.pop_front();
                    if (t.we) begin
                        e = t.wdata;
                        if (t.addr == 16'hFFFF) io_m = t.wdata;
                        else if (t.addr != 16'hFFFE) mem_m[t.addr[9:0]] = t.wdata;
                    end else if (t.addr == 16'hFFFF) begin
                        e = io_m;
                    end else if (t.addr == 16'hFFFE) begin
                        e = io_in;
                    end else begin
                        e = mem_m[t.addr[9:0]];
                    end
                    chk("rsp_cycle", cyc, t.cyc);
                    chk("rsp_data", {16'd0, rsp_rdata}, {16'd0, e});
                end
            end
            if (req_ready && req_valid) begin
                if (stream && have_last) chk("spacing_w1", cyc - last_acc, W + 2);
                have_last = stream;
                last_acc  = cyc;
                q.push_back('{req_we, req_addr, req_wdata, cyc + 1 + W});
            end
            if (!stream) have_last = 1'b0;
        end
        prev_rsp = rsp_valid;
    end

    always @(negedge CLK) begin
        txn_t t;
        cyc0++;
        if (rst0_n) begin
            if (rsp0) begin
                chk("rsp0_gap", {31'd0, prev_rsp0}, 32'd0);
                if (q0.size() == 0) begin
                    chk("rsp0_spurious", 32'd1, 32'd0);
                end else begin
                    t = q0.pop_front();
                    chk("rsp0_cycle", cyc0, t.cyc);
                    chk("rsp0_data", {16'd0, rdata0}, {16'd0, t.wdata});
                end
            end
            if (ready0 && valid0) begin
                if (have_last0) chk("spacing_w0", cyc0 - last_acc0, 2);
                have_last0 = 1'b1;
                last_acc0  = cyc0;
                q0.push_back('{1'b1, 16'h0007, wdata0, cyc0 + 1});
            end
            if (!valid0) have_last0 = 1'b0;
        end
        prev_rsp0 = rsp0;
    end

    task automatic req(input logic we, input logic [15:0] addr,
                       input logic [15:0] wdata);
        int n;
        @(posedge CLK);
        #2;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        n = 0;
        @(negedge CLK);
        while (!req_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("accept_timeout", n, 0);
        @(posedge CLK);
        #2;
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = 16'($urandom);
        req_wdata = 16'($urandom);
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("rsp_timeout", {31'd0, n >= 20}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rdata", {16'd0, rsp_rdata}, 32'd0);
        chk("rst_io_out", {16'd0, io_out}, 32'd0);
        @(posedge CLK);
        #2;
        RST_N  = 1'b1;
        rst0_n = 1'b1;
        @(negedge CLK);
        chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

        req(1'b1, 16'h0005, 16'h1234);
        req(1'b0, 16'h0005, 16'h0000);

        req(1'b1, 16'hFFFF, 16'hBEEF);
        chk("io_out_beef", {16'd0, io_out}, 32'h0000BEEF);
        req(1'b0, 16'hFFFF, 16'h0000);

        io_in = 16'h00A5;
        repeat (3) @(negedge CLK);
        req(1'b0, 16'hFFFE, 16'h0000);
        req(1'b1, 16'hFFFE, 16'h5555);
        chk("io_out_kept", {16'd0, io_out}, 32'h0000BEEF);
        req(1'b0, 16'hFFFF, 16'h0000);
        req(1'b0, 16'h0005, 16'h0000);

        req(1'b1, 16'h0403, 16'h7777);
        req(1'b0, 16'h0003, 16'h0000);

        // Continuous valid: accept spacing checked by the monitors.
        @(posedge CLK);
        #2;
        stream    = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 16'h0005;
        valid0    = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge CLK);
            #2;
            wdata0 = 16'($urandom);
        end
        req_valid = 1'b0;
        valid0    = 1'b0;
        stream    = 1'b0;
        repeat (4) @(negedge CLK);
        chk("stream_drain", q.size(), 0);
        chk("stream0_drain", q0.size(), 0);

        // Reset lands while the io_out write is still waiting.
        @(posedge CLK);
        #2;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 16'hFFFF;
        req_wdata = 16'h4242;
        @(posedge CLK);
        #2;
        req_valid = 1'b0;
        @(negedge CLK);
        chk("in_wait", {31'd0, req_ready}, 32'd0);
        #2;
        RST_N = 1'b0;
        @(negedge CLK);
        chk("rst_mid_io_out", {16'd0, io_out}, 32'd0);
        @(posedge CLK);
        #2;
        RST_N = 1'b1;
        @(negedge CLK);
        chk("ready_after_mid_rst", {31'd0, req_ready}, 32'd1);
        repeat (4) begin
            @(negedge CLK);
            chk("no_rsp_after_rst", {31'd0, rsp_valid}, 32'd0);
        end
        chk("io_out_zero", {16'd0, io_out}, 32'd0);

        req(1'b0, 16'h0005, 16'h0000);
        req(1'b0, 16'hFFFF, 16'h0000);

        repeat (3) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
